// File: rtl/plb_dac_if.sv
// PLB IPIF bus-side signal group between the IPIF and the DAC user logic.
// MSB-first IPIF vectors map onto descending ranges: RdCE/WrCE[C_NUM_REG-1] is IPIF bit 0 (CTRL).
interface plb_dac_if #(
  parameter int C_SLV_DWIDTH = 32,
  parameter int C_NUM_REG    = 2
);
  logic [C_SLV_DWIDTH-1:0]   Bus2IP_Data;
  logic [C_SLV_DWIDTH/8-1:0] Bus2IP_BE;
  logic [C_NUM_REG-1:0]      Bus2IP_RdCE;
  logic [C_NUM_REG-1:0]      Bus2IP_WrCE;
  logic [C_SLV_DWIDTH-1:0]   IP2Bus_Data;
  logic                      IP2Bus_RdAck;
  logic                      IP2Bus_WrAck;
  logic                      IP2Bus_Error;

  modport master (
    output Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

  modport slave (
    input  Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/plb_dac_user_logic.sv
// PLB IPIF user logic: CTRL/DATA software registers and a divided-clock engine
// that feeds 10-bit samples to a parallel DAC.
module plb_dac_user_logic #(
  parameter int C_SLV_DWIDTH = 32,
  parameter int C_NUM_REG    = 2,
  parameter int C_CLK_DIV    = 4
) (
  input  logic       Bus2IP_Clk,
  input  logic       Bus2IP_Reset,
  plb_dac_if.slave   bus,
  output logic [9:0] IP2DAC_Data,
  output logic       IP2DAC_DCLKIO,
  output logic       IP2DAC_Clkout,
  output logic       IP2DAC_PinMD,
  output logic       IP2DAC_ClkMD,
  output logic       IP2DAC_Format,
  output logic       IP2DAC_PWRDN
);

  localparam int CTRL_CE = C_NUM_REG - 1;
  localparam int DATA_CE = C_NUM_REG - 2;
  localparam int NBYTE   = C_SLV_DWIDTH / 8;
  localparam int DIV_W   = (C_CLK_DIV > 2) ? $clog2(C_CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(C_CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(C_CLK_DIV / 2);

  logic [C_SLV_DWIDTH-1:0] ctrl_q, ctrl_d;
  logic [C_SLV_DWIDTH-1:0] data_q, data_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    half_q, half_d;
  logic [9:0]              dac_q, dac_d;
  logic                    dclk_q, dclk_d;
  logic                    pwrdn_q, format_q, clkmd_q;
  logic                    en, dual;

  assign en   = ctrl_q[0];
  assign dual = ctrl_q[1];

  // Byte-lane merge; both registers may be written in the same cycle.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    for (int b = 0; b < NBYTE; b++) begin
      if (bus.Bus2IP_BE[b]) begin
        if (bus.Bus2IP_WrCE[CTRL_CE]) ctrl_d[8*b +: 8] = bus.Bus2IP_Data[8*b +: 8];
        if (bus.Bus2IP_WrCE[DATA_CE]) data_d[8*b +: 8] = bus.Bus2IP_Data[8*b +: 8];
      end
    end
  end

  assign bus.IP2Bus_WrAck = |bus.Bus2IP_WrCE;
  assign bus.IP2Bus_RdAck = |bus.Bus2IP_RdCE;
  assign bus.IP2Bus_Error = 1'b0;

  always_comb begin
    bus.IP2Bus_Data = '0;
    if (bus.Bus2IP_RdCE[CTRL_CE])      bus.IP2Bus_Data = ctrl_q;
    else if (bus.Bus2IP_RdCE[DATA_CE]) bus.IP2Bus_Data = data_q;
  end

  // Sample is latched only at divider 0, so a DATA write never shows up mid-period.
  always_comb begin
    div_d  = div_q;
    half_d = half_q;
    dac_d  = dac_q;
    dclk_d = dclk_q;
    if (!en) begin
      div_d  = '0;
      half_d = 1'b0;
      dac_d  = '0;
      dclk_d = 1'b0;
    end else begin
      div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      dclk_d = (div_q >= DIV_HALF);
      if (div_q == '0) begin
        dac_d  = (dual && half_q) ? data_q[25:16] : data_q[9:0];
        half_d = dual & ~half_q;
      end
    end
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Reset) begin
    if (!Bus2IP_Reset) begin
      ctrl_q   <= '0;
      data_q   <= '0;
      div_q    <= '0;
      half_q   <= 1'b0;
      dac_q    <= '0;
      dclk_q   <= 1'b0;
      pwrdn_q  <= 1'b1;
      format_q <= 1'b0;
      clkmd_q  <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      data_q   <= data_d;
      div_q    <= div_d;
      half_q   <= half_d;
      dac_q    <= dac_d;
      dclk_q   <= dclk_d;
      pwrdn_q  <= ~ctrl_q[0];
      format_q <= ctrl_q[2];
      clkmd_q  <= ctrl_q[3];
    end
  end

  assign IP2DAC_Data   = dac_q;
  assign IP2DAC_DCLKIO = dclk_q;
  assign IP2DAC_Clkout = dclk_q;
  assign IP2DAC_PinMD  = 1'b1;
  assign IP2DAC_ClkMD  = clkmd_q;
  assign IP2DAC_Format = format_q;
  assign IP2DAC_PWRDN  = pwrdn_q;

endmodule

// File: tb/tb_plb_dac_user_logic.sv
// Scoreboard bench for plb_dac_user_logic: expected read data and DAC samples are
// queued by the driver and consumed by a monitor on RdAck and on each DCLK rising edge.
module tb_plb_dac_user_logic;

  localparam logic [1:0] CE_CTRL = 2'b10;
  localparam logic [1:0] CE_DATA = 2'b01;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] dac_data;
  logic       dclk, clkout, pinmd, clkmd, fmt, pwrdn;

  plb_dac_if #(.C_SLV_DWIDTH(32), .C_NUM_REG(2)) bus ();

  plb_dac_user_logic #(.C_SLV_DWIDTH(32), .C_NUM_REG(2), .C_CLK_DIV(4)) dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Reset  (rst_n),
    .bus           (bus),
    .IP2DAC_Data   (dac_data),
    .IP2DAC_DCLKIO (dclk),
    .IP2DAC_Clkout (clkout),
    .IP2DAC_PinMD  (pinmd),
    .IP2DAC_ClkMD  (clkmd),
    .IP2DAC_Format (fmt),
    .IP2DAC_PWRDN  (pwrdn)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_wr = 0;
  int          wr_ack_cnt = 0;
  logic [31:0] rd_q[$];
  logic [9:0]  dac_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ce, input logic [3:0] be, input logic [31:0] d);
    bus.Bus2IP_WrCE = ce;
    bus.Bus2IP_BE   = be;
    bus.Bus2IP_Data = d;
    exp_wr++;
    tick(1);
    bus.Bus2IP_WrCE = '0;
    bus.Bus2IP_BE   = '0;
    bus.Bus2IP_Data = '0;
  endtask

  task automatic rd(input logic [1:0] ce, input logic [31:0] exp);
    rd_q.push_back(exp);
    bus.Bus2IP_RdCE = ce;
    tick(1);
    bus.Bus2IP_RdCE = '0;
  endtask

  // Monitor: pops expectations whenever the DUT presents read data or a DAC strobe.
  initial begin
    logic dclk_prev;
    dclk_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.IP2Bus_WrAck === 1'b1) wr_ack_cnt++;
      if (bus.IP2Bus_RdAck === 1'b1) begin
        if (rd_q.size() == 0) check("unexpected_rdack", 32'd1, 32'd0);
        else check("read_data", bus.IP2Bus_Data, rd_q.pop_front());
      end
      if (dclk === 1'b1 && dclk_prev === 1'b0 && dac_q.size() > 0)
        check("dac_sample", 32'(dac_data), 32'(dac_q.pop_front()));
      dclk_prev = dclk;
    end
  end

  task automatic check_dclk_shape();
    int hi, lo, guard;
    hi = 0; lo = 0; guard = 0;
    // find a rising edge
    do begin
      @(negedge clk);
      guard++;
    end while (!(dclk === 1'b0) && guard < 20);
    while (dclk !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    hi = 1;
    while (guard < 60) begin
      @(negedge clk);
      guard++;
      if (dclk === 1'b1) hi++;
      else break;
    end
    lo = 1;
    while (guard < 80) begin
      @(negedge clk);
      guard++;
      if (dclk === 1'b0) lo++;
      else break;
    end
    check("dclk_high_cycles", 32'(hi), 32'd2);
    check("dclk_low_cycles", 32'(lo), 32'd2);
    tick(0);
  endtask

  // Stop the engine, load DATA, queue n expected samples, then enable with ctrl.
  task automatic run_vec(input string name, input logic [31:0] ctrl, input logic [31:0] data,
                         input logic [39:0] ev, input int n, input bit shape);
    int guard;
    wr(CE_CTRL, BE_ALL, 32'h0);
    tick(3);
    wr(CE_DATA, BE_ALL, data);
    for (int i = 0; i < n; i++) dac_q.push_back(ev[10*i +: 10]);
    wr(CE_CTRL, BE_ALL, ctrl);
    if (shape) check_dclk_shape();
    guard = 0;
    while (dac_q.size() > 0 && guard < n * 4 + 12) begin
      tick(1);
      guard++;
    end
    if (dac_q.size() > 0) begin
      check({name, "_timeout"}, 32'(dac_q.size()), 32'd0);
      dac_q.delete();
    end
  endtask

  initial begin
    int guard;
    bus.Bus2IP_Data = '0;
    bus.Bus2IP_BE   = '0;
    bus.Bus2IP_RdCE = '0;
    bus.Bus2IP_WrCE = '0;
    #23;
    check("rst_pwrdn", 32'(pwrdn), 32'd1);
    check("rst_dclk", 32'(dclk), 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("rst_dac_data", 32'(dac_data), 32'h0);
    check("rst_clkout", 32'(clkout), 32'd0);
    check("rst_pinmd", 32'(pinmd), 32'd1);
    check("rst_error", 32'(bus.IP2Bus_Error), 32'd0);
    check("rst_clkmd", 32'(clkmd), 32'd0);
    check("rst_format", 32'(fmt), 32'd0);
    check("rst_pwrdn_after", 32'(pwrdn), 32'd1);
    rd(CE_CTRL, 32'h0);
    rd(CE_DATA, 32'h0);

    run_vec("single_1234", 32'h1, 32'h0000_1234,
            {10'h234, 10'h234, 10'h234, 10'h234}, 4, 1'b1);
    check("en_pwrdn", 32'(pwrdn), 32'd0);
    check("clkout_eq_dclk", 32'(clkout), 32'(dclk));
    run_vec("single_lo0", 32'h1, 32'h1234_0000,
            {10'h0, 10'h000, 10'h000, 10'h000}, 3, 1'b0);
    run_vec("single_2345", 32'h1, 32'h1234_2345,
            {10'h0, 10'h345, 10'h345, 10'h345}, 3, 1'b0);
    run_vec("dual_2345", 32'h3, 32'h1234_2345,
            {10'h234, 10'h345, 10'h234, 10'h345}, 4, 1'b0);
    run_vec("dual_1234", 32'h3, 32'h0000_1234,
            {10'h000, 10'h234, 10'h000, 10'h234}, 4, 1'b0);
    run_vec("fmt_clkmd", 32'hD, 32'h0000_03FF,
            {10'h0, 10'h0, 10'h3FF, 10'h3FF}, 2, 1'b0);
    check("format_set", 32'(fmt), 32'd1);
    check("clkmd_set", 32'(clkmd), 32'd1);
    run_vec("upper_ctrl", 32'hA5A5_A5F1, 32'h02AA_0155,
            {10'h0, 10'h0, 10'h155, 10'h155}, 2, 1'b0);
    check("upper_format", 32'(fmt), 32'd0);
    rd(CE_CTRL, 32'hA5A5_A5F1);

    // Stop in the high half of a DAC period.
    guard = 0;
    while (dclk !== 1'b1 && guard < 10) begin
      tick(1);
      guard++;
    end
    check("stop_found_dclk_high", 32'(dclk), 32'd1);
    wr(CE_CTRL, BE_ALL, 32'h0);
    check("stop_pwrdn_latency", 32'(pwrdn), 32'd0);
    tick(1);
    check("stop_pwrdn", 32'(pwrdn), 32'd1);
    check("stop_dclk", 32'(dclk), 32'd0);
    check("stop_dac_data", 32'(dac_data), 32'h0);
    rd(CE_CTRL, 32'h0);

    wr(CE_DATA, BE_ALL, 32'h1234_2345);
    wr(CE_DATA, 4'b0001, 32'hFFFF_FFFF);
    rd(CE_DATA, 32'h1234_23FF);
    wr(CE_DATA, 4'b1000, 32'hAB00_0000);
    rd(CE_DATA, 32'hAB34_23FF);
    wr(2'b11, 4'b0011, 32'h0000_C0DE);
    rd(CE_CTRL, 32'h0000_C0DE);
    rd(CE_DATA, 32'hAB34_C0DE);
    tick(2);
    check("c0de_pwrdn", 32'(pwrdn), 32'd1);
    check("c0de_format", 32'(fmt), 32'd1);
    check("c0de_clkmd", 32'(clkmd), 32'd1);
    check("c0de_dclk_idle", 32'(dclk), 32'd0);

    tick(2);
    check("wrack_count", 32'(wr_ack_cnt), 32'(exp_wr));
    check("reads_pending", 32'(rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
